// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: walks columns, debounces a hit, offers one key event
// per press over a valid/ready handshake, then waits for a debounced release.
module keypad_scan_ctrl #(
  parameter int SETTLE_CYCLES   = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       row_hit,
  input  logic [1:0] row_code,
  output logic [1:0] col_selector,
  output logic       key_valid,
  input  logic       key_ready,
  output logic [3:0] key,
  output logic       keytype,
  output logic       busy
);

  localparam int SW = (SETTLE_CYCLES   > 1) ? $clog2(SETTLE_CYCLES)   : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [1:0] SCAN     = 2'd0;
  localparam logic [1:0] DEBOUNCE = 2'd1;
  localparam logic [1:0] EMIT     = 2'd2;
  localparam logic [1:0] HELD     = 2'd3;

  logic [1:0]    state;
  logic [SW-1:0] settle_cnt;
  logic [DW-1:0] deb_cnt;
  logic [1:0]    cand_col;
  logic [1:0]    cand_row;
  logic          settle_done;
  logic          deb_done;
  logic          row_match;
  logic [3:0]    map_key;

  function automatic logic [3:0] key_map(input logic [1:0] c, input logic [1:0] r);
    logic [3:0] k;
    case ({c, r})
      4'b00_11: k = 4'h1;  4'b00_10: k = 4'h4;  4'b00_01: k = 4'h7;  4'b00_00: k = 4'hF;
      4'b01_11: k = 4'h2;  4'b01_10: k = 4'h5;  4'b01_01: k = 4'h8;  4'b01_00: k = 4'h0;
      4'b10_11: k = 4'h3;  4'b10_10: k = 4'h6;  4'b10_01: k = 4'h9;  4'b10_00: k = 4'hE;
      4'b11_11: k = 4'hA;  4'b11_10: k = 4'hB;  4'b11_01: k = 4'hC;  default:  k = 4'hD;
    endcase
    return k;
  endfunction

  assign settle_done = (settle_cnt == SW'(SETTLE_CYCLES - 1));
  assign deb_done    = (deb_cnt == DW'(DEBOUNCE_CYCLES - 1));
  assign row_match   = row_hit && (row_code == cand_row);
  assign map_key     = key_map(cand_col, cand_row);

  // One debounce counter serves both the press (DEBOUNCE) and release (HELD) phases.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= SCAN;
      col_selector <= 2'd0;
      key_valid    <= 1'b0;
      key          <= 4'd0;
      keytype      <= 1'b0;
      busy         <= 1'b0;
      settle_cnt   <= '0;
      deb_cnt      <= '0;
      cand_col     <= 2'd0;
      cand_row     <= 2'd0;
    end else begin
      case (state)
        SCAN: if (enable) begin
          if (settle_done) begin
            settle_cnt <= '0;
            if (row_hit) begin
              cand_col <= col_selector;
              cand_row <= row_code;
              deb_cnt  <= '0;
              state    <= DEBOUNCE;
              busy     <= 1'b1;
            end else begin
              col_selector <= col_selector + 2'd1;
            end
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        DEBOUNCE: begin
          if (!enable || !row_match) begin
            state      <= SCAN;
            busy       <= 1'b0;
            deb_cnt    <= '0;
            settle_cnt <= '0;
          end else if (deb_done) begin
            deb_cnt   <= '0;
            state     <= EMIT;
            key_valid <= 1'b1;
            key       <= map_key;
            keytype   <= (map_key <= 4'd9);
          end else begin
            deb_cnt <= deb_cnt + DW'(1);
          end
        end
        EMIT: if (key_ready) begin
          key_valid <= 1'b0;
          deb_cnt   <= '0;
          state     <= HELD;
        end
        HELD: begin
          if (row_hit) begin
            deb_cnt <= '0;
          end else if (deb_done) begin
            deb_cnt      <= '0;
            settle_cnt   <= '0;
            col_selector <= col_selector + 2'd1;
            state        <= SCAN;
            busy         <= 1'b0;
          end else begin
            deb_cnt <= deb_cnt + DW'(1);
          end
        end
        default: begin
          state <= SCAN;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a keypad model drives rows from col_selector;
// expected events go into a queue that a handshake monitor drains and checks.
module tb_keypad_scan_ctrl;
  localparam int SETTLE = 2;
  localparam int DEB    = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b1;
  logic       key_ready = 1'b0;
  logic       row_hit;
  logic [1:0] row_code;
  logic [1:0] col_selector;
  logic       key_valid;
  logic [3:0] key;
  logic       keytype;
  logic       busy;

  logic       pressed = 1'b0;
  logic [1:0] pcol = 2'd0;
  logic [1:0] prow = 2'd0;

  int checks = 0;
  int errors = 0;
  int vcycles = 0;
  int accepted = 0;
  logic [3:0] exp_q[$];
  bit rnd_ready = 1'b0;

  keypad_scan_ctrl #(.SETTLE_CYCLES(SETTLE), .DEBOUNCE_CYCLES(DEB)) dut (
    .clock(clock), .reset(reset), .enable(enable), .row_hit(row_hit),
    .row_code(row_code), .col_selector(col_selector), .key_valid(key_valid),
    .key_ready(key_ready), .key(key), .keytype(keytype), .busy(busy)
  );

  assign row_hit  = pressed && (col_selector == pcol);
  assign row_code = row_hit ? prow : 2'b00;

  always #5 clock = ~clock;

  // Phone-style layout: digits 1..9 read left-to-right top-down, bottom row F 0 E,
  // last column A..D top-down. Row code 3 is the top row.
  function automatic logic [3:0] ref_key(input int c, input int r);
    int top;
    top = 3 - r;
    if (c == 3) return 4'(10 + top);
    if (top < 3) return 4'(top * 3 + c + 1);
    if (c == 0) return 4'hF;
    if (c == 1) return 4'h0;
    return 4'hE;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (rnd_ready) key_ready = ($urandom_range(0, 2) == 0);
  endtask

  task automatic press(input int c, input int r);
    pcol = 2'(c);
    prow = 2'(r);
    pressed = 1'b1;
  endtask

  task automatic wait_valid(input string name, input int lim);
    int n;
    n = 0;
    while (!key_valid && n < lim) begin tick(); n++; end
    if (!key_valid) check({name, "_timeout_valid"}, 0, 1);
  endtask

  task automatic wait_busy(input string name, input int lim);
    int n;
    n = 0;
    while (!busy && n < lim) begin tick(); n++; end
    if (!busy) check({name, "_timeout_busy"}, 0, 1);
  endtask

  task automatic wait_idle(input string name, input int lim);
    int n;
    n = 0;
    while (busy && n < lim) begin tick(); n++; end
    if (busy) check({name, "_timeout_idle"}, 1, 0);
  endtask

  task automatic wait_accept(input string name, input int a0, input int lim);
    int n;
    n = 0;
    while (accepted == a0 && n < lim) begin tick(); n++; end
    if (accepted == a0) check({name, "_timeout_accept"}, 0, 1);
  endtask

  // Handshake monitor: pops an expected key on every accepted event and
  // checks that an offered-but-unaccepted key does not change.
  logic       pend = 1'b0;
  logic [3:0] pend_key = 4'd0;
  logic [3:0] mon_e;
  always @(negedge clock) begin
    if (key_valid) vcycles++;
    if (key_valid && pend) check("key_stable", key, pend_key);
    if (key_valid && key_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got key %0d expected no event at %0t", key, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("event_key", key, mon_e);
        check("event_keytype", keytype, (mon_e <= 4'd9));
      end
      accepted++;
    end
    pend     <= key_valid && !key_ready;
    pend_key <= key;
  end

  initial begin
    int v0, a0, n;
    repeat (3) tick();
    check("rst_col", col_selector, 0);
    check("rst_valid", key_valid, 0);
    check("rst_key", key, 0);
    check("rst_keytype", keytype, 0);
    check("rst_busy", busy, 0);

    // Idle scan order with no key pressed
    reset = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      check("scan_col", col_selector, (i / SETTLE) % 4);
      check("scan_busy", busy, 0);
    end
    tick();

    // Key 5 with ready always high: one single-cycle event, resume at col 2
    v0 = vcycles; a0 = accepted;
    key_ready = 1'b1;
    exp_q.push_back(ref_key(1, 2));
    press(1, 2);
    wait_accept("k5", a0, 200);
    check("k5_valid_cycles", vcycles - v0, 1);
    pressed = 1'b0;
    n = 0;
    while (busy && n < 50) begin tick(); n++; end
    check("k5_release_cycles", n, DEB);
    check("k5_resume_col", col_selector, 2);

    // Key D held off by ready=0 for 20 cycles, released mid-wait
    key_ready = 1'b0;
    v0 = vcycles; a0 = accepted;
    exp_q.push_back(ref_key(3, 0));
    press(3, 0);
    wait_valid("kd", 200);
    for (int i = 0; i < 20; i++) begin
      if (i == 10) pressed = 1'b0;
      if (i == 0 || i == 19) begin
        check("kd_valid_held", key_valid, 1);
        check("kd_key", key, 13);
      end
      tick();
    end
    check("kd_valid_cycles", vcycles - v0, 20);
    key_ready = 1'b1;
    wait_accept("kd", a0, 50);
    wait_idle("kd", 100);

    // Two-cycle bounce on col 0: no event, back to scanning on col 0
    v0 = vcycles;
    press(0, 3);
    wait_busy("bounce", 100);
    tick();
    pressed = 1'b0;
    wait_idle("bounce", 50);
    check("bounce_col", col_selector, 0);
    repeat (6) tick();
    check("bounce_no_event", vcycles - v0, 0);

    // Dropping enable mid-debounce aborts without an event
    v0 = vcycles;
    press(2, 1);
    wait_busy("en", 100);
    enable = 1'b0;
    tick();
    check("en_abort_busy", busy, 0);
    pressed = 1'b0;
    enable = 1'b1;
    repeat (10) tick();
    check("en_no_event", vcycles - v0, 0);

    // Reset mid-EMIT discards the pending event
    key_ready = 1'b0;
    a0 = accepted;
    press(0, 1);
    wait_valid("rstemit", 200);
    reset = 1'b0;
    tick();
    check("rstemit_valid", key_valid, 0);
    check("rstemit_col", col_selector, 0);
    check("rstemit_busy", busy, 0);
    check("rstemit_key", key, 0);
    reset = 1'b1;
    pressed = 1'b0;
    key_ready = 1'b1;
    repeat (10) tick();
    check("rstemit_no_accept", accepted - a0, 0);

    // Key 9 held through several full scans emits once; then '#' -> E
    a0 = accepted;
    exp_q.push_back(ref_key(2, 1));
    press(2, 1);
    repeat (100) tick();
    pressed = 1'b0;
    wait_idle("k9", 100);
    check("k9_single_event", accepted - a0, 1);
    a0 = accepted;
    exp_q.push_back(ref_key(2, 0));
    press(2, 0);
    wait_accept("kE", a0, 200);
    pressed = 1'b0;
    wait_idle("kE", 100);

    // Randomized presses and bounces with random consumer back-pressure
    rnd_ready = 1'b1;
    for (int it = 0; it < 30; it++) begin
      int c, r;
      c = $urandom_range(0, 3);
      r = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) begin
        press(c, r);
        repeat ($urandom_range(1, 2)) tick();
        pressed = 1'b0;
        wait_idle("rnd_bounce", 50);
      end else begin
        a0 = accepted;
        exp_q.push_back(ref_key(c, r));
        press(c, r);
        wait_accept("rnd", a0, 400);
        repeat ($urandom_range(0, 20)) tick();
        pressed = 1'b0;
        wait_idle("rnd", 200);
      end
      repeat ($urandom_range(2, 6)) tick();
    end
    rnd_ready = 1'b0;
    key_ready = 1'b0;
    repeat (10) tick();
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
